// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg
// Shared definitions for the bit serializer slice: the two-state FSM
// encoding and the default data width / shift order used by the top.
package bit_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH     = 8;
  localparam bit DEFAULT_MSB_FIRST = 1'b1;

endpackage

// File: rtl/bit_serializer_counter.sv
// bit_counter
// Modulo-WIDTH bit position counter for the serializer.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, forces count to 0
//   clear - synchronous clear back to 0 (higher priority than en)
//   en    - advance the count by one, wrapping after WIDTH-1
//   tc    - terminal count flag, high while count = WIDTH-1
module bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] MAX_COUNT = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  // Clear wins over enable so a new word always starts at position 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      if (count == MAX_COUNT) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign tc = (count == MAX_COUNT);

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer
// Accepts a parallel word on a valid/ready handshake and shifts it out one
// bit per cycle. A new word may be accepted on the final bit of the current
// word, giving a gapless stream across back-to-back words.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   data_in    - parallel word to serialize (WIDTH bits)
//   data_valid - data_in holds a word for transfer
//   data_ready - block can accept a word this cycle (combinational)
//   bit_out    - serial data bit (registered)
//   bit_valid  - bit_out carries a data bit (registered)
//   last       - bit_out is the final bit of the current word
//   busy       - a word is being shifted (registered)
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = DEFAULT_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             transfer;
  logic             tc;
  logic             load_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] next_rest;

  // Ready on the last bit lets the next word follow without an idle cycle.
  assign last       = (state == SHIFT) && tc;
  assign data_ready = (state == IDLE) || last;
  assign transfer   = data_valid && data_ready;

  // The counter restarts on every accepted word and also on the final bit,
  // so it is back at 0 whether we reload or fall back to IDLE.
  bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(transfer || last),
    .en   (state == SHIFT),
    .tc   (tc)
  );

  // Shift order is fixed at elaboration. The first bit goes straight to
  // bit_out at load time; shreg holds the remaining bits, pre-shifted.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign load_bit  = data_in[WIDTH-1];
      assign load_rest = {data_in[WIDTH-2:0], 1'b0};
      assign next_bit  = shreg[WIDTH-1];
      assign next_rest = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign load_bit  = data_in[0];
      assign load_rest = {1'b0, data_in[WIDTH-1:1]};
      assign next_bit  = shreg[0];
      assign next_rest = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  // Single FSM block: a transfer always (re)loads, a mid-word SHIFT cycle
  // advances, and anything else (IDLE without a word, or the last bit
  // without a follow-on word) parks everything at zero in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (transfer) begin
      state     <= SHIFT;
      shreg     <= load_rest;
      bit_out   <= load_bit;
      bit_valid <= 1'b1;
      busy      <= 1'b1;
    end else if ((state == SHIFT) && !last) begin
      state     <= SHIFT;
      shreg     <= next_rest;
      bit_out   <= next_bit;
      bit_valid <= 1'b1;
      busy      <= 1'b1;
    end else begin
      state     <= IDLE;
      shreg     <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
// Drives an MSB-first and an LSB-first 8-bit serializer from the same
// inputs and compares every output against hand-computed bit streams.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_valid;
  logic [7:0] data_in;

  logic m_ready, m_bit, m_valid, m_last, m_busy;
  logic l_ready, l_bit, l_valid, l_last, l_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serializer #(
    .WIDTH    (8),
    .MSB_FIRST(1'b1)
  ) dut_msb (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(m_ready),
    .bit_out   (m_bit),
    .bit_valid (m_valid),
    .last      (m_last),
    .busy      (m_busy)
  );

  bit_serializer #(
    .WIDTH    (8),
    .MSB_FIRST(1'b0)
  ) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(l_ready),
    .bit_out   (l_bit),
    .bit_valid (l_valid),
    .last      (l_last),
    .busy      (l_busy)
  );

  // Each sequence is written first-bit-leftmost: seq[7] is the bit expected
  // in the first cycle after the transfer.
  typedef struct {
    string      name;
    logic [7:0] word;
    logic [7:0] msb_seq;
    logic [7:0] lsb_seq;
  } vec_t;

  vec_t vecs[5];

  // Advance one cycle and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic checkShiftCycle(input string tag, input int i,
                                 input logic [7:0] ms, input logic [7:0] ls);
    logic exp_last;
    exp_last = (i == 7);
    checkOutput($sformatf("%s msb bit%0d", tag, i), m_bit, ms[7-i]);
    checkOutput($sformatf("%s lsb bit%0d", tag, i), l_bit, ls[7-i]);
    checkOutput($sformatf("%s msb valid%0d", tag, i), m_valid, 1'b1);
    checkOutput($sformatf("%s lsb valid%0d", tag, i), l_valid, 1'b1);
    checkOutput($sformatf("%s msb busy%0d", tag, i), m_busy, 1'b1);
    checkOutput($sformatf("%s lsb busy%0d", tag, i), l_busy, 1'b1);
    checkOutput($sformatf("%s msb last%0d", tag, i), m_last, exp_last);
    checkOutput($sformatf("%s lsb last%0d", tag, i), l_last, exp_last);
    checkOutput($sformatf("%s msb ready%0d", tag, i), m_ready, exp_last);
    checkOutput($sformatf("%s lsb ready%0d", tag, i), l_ready, exp_last);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " msb bit_out"}, m_bit, 1'b0);
    checkOutput({tag, " lsb bit_out"}, l_bit, 1'b0);
    checkOutput({tag, " msb bit_valid"}, m_valid, 1'b0);
    checkOutput({tag, " lsb bit_valid"}, l_valid, 1'b0);
    checkOutput({tag, " msb busy"}, m_busy, 1'b0);
    checkOutput({tag, " lsb busy"}, l_busy, 1'b0);
    checkOutput({tag, " msb last"}, m_last, 1'b0);
    checkOutput({tag, " lsb last"}, l_last, 1'b0);
    checkOutput({tag, " msb ready"}, m_ready, 1'b1);
    checkOutput({tag, " lsb ready"}, l_ready, 1'b1);
  endtask

  // Presents a word for one cycle from IDLE, then scrambles data_in so a
  // design that samples late is caught.
  task automatic applyStimulus(input logic [7:0] word);
    data_in    = word;
    data_valid = 1'b1;
    checkOutput("load msb ready", m_ready, 1'b1);
    checkOutput("load lsb ready", l_ready, 1'b1);
    step();
    data_valid = 1'b0;
    data_in    = ~word;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"A5", 8'hA5, 8'b1010_0101, 8'b1010_0101};
    vecs[1] = '{"01", 8'h01, 8'b0000_0001, 8'b1000_0000};
    vecs[2] = '{"81", 8'h81, 8'b1000_0001, 8'b1000_0001};
    vecs[3] = '{"96", 8'h96, 8'b1001_0110, 8'b0110_1001};
    vecs[4] = '{"12", 8'h12, 8'b0001_0010, 8'b0100_1000};

    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    step();
    step();
    checkOutput("reset msb bit_valid", m_valid, 1'b0);
    checkOutput("reset lsb busy", l_busy, 1'b0);
    rst = 1'b0;
    checkIdle("post reset");
    step();

    // Single words from IDLE, both shift orders.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].word);
      for (int i = 0; i < 8; i++) begin
        checkShiftCycle(vecs[v].name, i, vecs[v].msb_seq, vecs[v].lsb_seq);
        step();
      end
      checkIdle({vecs[v].name, " end"});
    end

    // 0xFF then 0x00 with data_valid held: 16 contiguous bits, no gap.
    data_in    = 8'hFF;
    data_valid = 1'b1;
    step();
    data_in = 8'h00;
    for (int j = 0; j < 16; j++) begin
      logic exp_bit;
      logic exp_last;
      if (j == 8) data_valid = 1'b0;
      exp_bit  = (j < 8);
      exp_last = (j == 7) || (j == 15);
      checkOutput($sformatf("b2b msb bit%0d", j), m_bit, exp_bit);
      checkOutput($sformatf("b2b lsb bit%0d", j), l_bit, exp_bit);
      checkOutput($sformatf("b2b msb valid%0d", j), m_valid, 1'b1);
      checkOutput($sformatf("b2b msb busy%0d", j), m_busy, 1'b1);
      checkOutput($sformatf("b2b msb last%0d", j), m_last, exp_last);
      checkOutput($sformatf("b2b msb ready%0d", j), m_ready, exp_last);
      step();
    end
    checkIdle("b2b end");

    // Word offered mid-shift is held off until the last bit.
    applyStimulus(8'h96);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        data_in    = 8'h3C;
        data_valid = 1'b1;
      end
      if (i == 4) data_in = 8'hFF;
      if (i == 6) data_in = 8'h3C;
      checkShiftCycle("hold 96", i, 8'b1001_0110, 8'b0110_1001);
      step();
    end
    data_valid = 1'b0;
    data_in    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checkShiftCycle("hold 3C", i, 8'b0011_1100, 8'b0011_1100);
      step();
    end
    checkIdle("hold end");

    // Reset at counter=4 while shifting 0xF0.
    applyStimulus(8'hF0);
    for (int i = 0; i < 5; i++) begin
      checkShiftCycle("rst F0", i, 8'b1111_0000, 8'b0000_1111);
      if (i < 4) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkIdle("mid reset");
    for (int k = 0; k < 6; k++) begin
      step();
      checkOutput($sformatf("residual msb valid%0d", k), m_valid, 1'b0);
      checkOutput($sformatf("residual lsb valid%0d", k), l_valid, 1'b0);
      checkOutput($sformatf("residual msb busy%0d", k), m_busy, 1'b0);
    end

    // data_valid during reset is ignored, then a clean load of 0x81.
    rst        = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'hFF;
    step();
    step();
    checkOutput("rst valid msb bit_valid", m_valid, 1'b0);
    checkOutput("rst valid lsb busy", l_busy, 1'b0);
    rst        = 1'b0;
    data_valid = 1'b0;
    checkIdle("rst valid release");
    applyStimulus(8'h81);
    for (int i = 0; i < 8; i++) begin
      checkShiftCycle("after rst 81", i, 8'b1000_0001, 8'b1000_0001);
      step();
    end
    checkIdle("after rst 81 end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, data word width; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 shifted first, 0 = bit 0 shifted first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_in  input  WIDTH  parallel word to serialize.
REQ-006 data_valid  input  1  data_in holds a word for transfer.
REQ-007 data_ready  output  1  block accepts a word this cycle.
REQ-008 bit_out  output  1  serial bit stream to the downstream serial-input sequence FSM.
REQ-009 bit_valid  output  1  bit_out carries a data bit this cycle.
REQ-010 last  output  1  bit_out is the final bit of the current word.
REQ-011 busy  output  1  a word is being shifted.

Function
REQ-012 States: IDLE and SHIFT only.
REQ-013 Transfer occurs when data_valid=1 and data_ready=1 in the same cycle; no other condition loads a word.
REQ-014 data_ready is combinational: 1 in IDLE; 1 in SHIFT only while last=1; 0 otherwise.
REQ-015 IDLE -> SHIFT on transfer; the first bit appears on bit_out in the cycle after transfer (latency 1).
REQ-016 In SHIFT, one new bit every cycle; WIDTH consecutive cycles with bit_valid=1 per word.
REQ-017 Bit counter runs 0..WIDTH-1 and is $clog2(WIDTH) bits wide; last=1 exactly when counter = WIDTH-1 and state = SHIFT.
REQ-018 SHIFT with last=1 and a transfer: the new word's first bit follows immediately the next cycle, with no idle gap and the counter restarting at 0.
REQ-019 SHIFT with last=1 and no transfer: return to IDLE next cycle.
REQ-020 In IDLE: bit_out=0, bit_valid=0, last=0, busy=0.
REQ-021 bit_out, bit_valid and busy are registered outputs; busy=1 exactly when state = SHIFT.
REQ-022 data_in changes while data_ready=0 have no effect; the word is captured only at transfer.
REQ-023 data_valid held high while data_ready=0 is not a transfer and is not dropped; it is accepted at the next cycle with data_ready=1.

Reset
REQ-024 rst=1 at a rising edge forces state IDLE, counter 0, shift register 0, bit_out=0, bit_valid=0, busy=0, regardless of current state.
REQ-025 Reset mid-word abandons the word; no remaining bits are emitted after reset deasserts.
REQ-026 data_ready=1 in the first cycle after rst deasserts.
REQ-027 data_valid is ignored during any cycle with rst=1.

Structure
REQ-028 Shared package holds the state encoding (IDLE=0, SHIFT=1) and the WIDTH/MSB_FIRST defaults.
REQ-029 One sub-module, bit_counter: a modulo-WIDTH counter with synchronous clear, an enable and a terminal-count flag that drives last.
REQ-030 The shift direction is chosen by MSB_FIRST at elaboration; no runtime mux.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, load 0xA5 -> bit_out 1,0,1,0,0,1,0,1 over cycles N+1..N+8; last=1 only at N+8; IDLE at N+9.
REQ-032 MSB_FIRST=0, load 0x01 -> bit_out 1,0,0,0,0,0,0,0; bit_valid high for exactly 8 cycles.
REQ-033 0xFF then 0x00, with data_valid held high -> second transfer on the last=1 cycle; 16 contiguous bit_valid cycles giving eight 1s then eight 0s; busy never drops.
REQ-034 data_valid=1 with 0x3C at counter=3 -> data_ready=0 and no load; 0x3C is accepted on the last=1 cycle and shifted next.
REQ-035 rst=1 at counter=4 while shifting 0xF0 -> next cycle bit_valid=0, busy=0, data_ready=1; no residual bits afterward.
REQ-036 Reset asserted with data_valid=1 -> no transfer; after release, data_ready=1 and a load of 0x81 yields 1,0,0,0,0,0,0,1.
